// File: rtl/gpio_core_pkg.sv
// Shared constants for the GPIO core: register select codes and emesh packet layout.
package gpio_core_pkg;

   // Register select values, taken from dstaddr[6:3]
   localparam logic [3:0] GPIO_DIR     = 4'd0;
   localparam logic [3:0] GPIO_IDATA   = 4'd1;
   localparam logic [3:0] GPIO_ODATA   = 4'd2;
   localparam logic [3:0] GPIO_OCLR    = 4'd3;
   localparam logic [3:0] GPIO_OSET    = 4'd4;
   localparam logic [3:0] GPIO_OXOR    = 4'd5;
   localparam logic [3:0] GPIO_IMASK   = 4'd6;
   localparam logic [3:0] GPIO_ITYPE   = 4'd7;
   localparam logic [3:0] GPIO_IPOL    = 4'd8;
   localparam logic [3:0] GPIO_ILAT    = 4'd9;
   localparam logic [3:0] GPIO_ILATCLR = 4'd10;

   // Packet field offsets; data follows dstaddr directly, so its LSB is PKT_DST_LSB + AW
   localparam int unsigned PKT_WRITE_BIT = 0;
   localparam int unsigned PKT_DST_LSB   = 8;
   localparam int unsigned PKT_SEL_LSB   = 3;  // register select offset inside dstaddr

endpackage

// File: rtl/gpio_core_if.sv
// Register bus bundle between an emesh master and the GPIO core.
interface gpio_core_if #(
   parameter int unsigned PW = 104
);
   logic          reg_access;
   logic [PW-1:0] reg_packet;
   logic [31:0]   reg_rdata;

   modport master (output reg_access, output reg_packet, input reg_rdata);
   modport slave  (input reg_access, input reg_packet, output reg_rdata);
endinterface

// File: rtl/gpio_sync.sv
// N-bit two-flop synchronizer for asynchronous pin inputs.
module gpio_sync #(
   parameter int unsigned N = 24
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] meta_q;
   logic [N-1:0] sync_q;

   // Two-stage capture of the raw pins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/gpio_core.sv
// Memory-mapped GPIO: direction, output data with set/clear/toggle, synchronized inputs
// and latched edge/level interrupts behind an emesh register bus.
module gpio_core
   import gpio_core_pkg::*;
#(
   parameter int unsigned N  = 24,
   parameter int unsigned AW = 32,
   parameter int unsigned PW = 2 * AW + 40,
   parameter int unsigned ID = 0
) (
   input  logic          clk,
   input  logic          nreset,
   gpio_core_if.slave    bus,
   input  logic [N-1:0]  gpio_in,
   output logic [N-1:0]  gpio_out,
   output logic [N-1:0]  gpio_en,
   output logic          gpio_irq,
   output logic [31:0]   gpio_ilat
);

   logic [AW-1:0] dstaddr;
   logic [AW-1:0] data;
   logic [3:0]    sel;
   logic [N-1:0]  wdata;
   logic          write_en;
   logic          read_en;

   assign dstaddr  = bus.reg_packet[PKT_DST_LSB +: AW];
   assign data     = bus.reg_packet[PKT_DST_LSB + AW +: AW];
   assign sel      = dstaddr[PKT_SEL_LSB +: 4];
   assign wdata    = data[N-1:0];
   assign write_en = bus.reg_access & bus.reg_packet[PKT_WRITE_BIT];
   assign read_en  = bus.reg_access & ~bus.reg_packet[PKT_WRITE_BIT];

   // datamode, ctrlmode, srcaddr, upper address/data bits and the block id are not decoded
   logic unused_pkt;
   assign unused_pkt = ^{bus.reg_packet, dstaddr, data, 32'(ID), 32'(PW)};

   logic [N-1:0] sync;
   logic [N-1:0] prev_q;
   logic [N-1:0] dir_q, dir_d;
   logic [N-1:0] odata_q, odata_d;
   logic [N-1:0] imask_q, imask_d;
   logic [N-1:0] itype_q, itype_d;
   logic [N-1:0] ipol_q, ipol_d;
   logic [N-1:0] ilat_q, ilat_d;
   logic [N-1:0] ilat_clr;
   logic [N-1:0] edge_hit, level_hit, irq_event;
   logic [N-1:0] rd_val;
   logic [31:0]  rdata_q;
   logic         irq_q;

   gpio_sync #(
      .N (N)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (nreset),
      .d_i    (gpio_in),
      .q_o    (sync)
   );

   // Register write decode and atomic output updates
   always_comb begin
      dir_d    = dir_q;
      odata_d  = odata_q;
      imask_d  = imask_q;
      itype_d  = itype_q;
      ipol_d   = ipol_q;
      ilat_clr = '0;
      if (write_en) begin
         case (sel)
            GPIO_DIR:     dir_d    = wdata;
            GPIO_ODATA:   odata_d  = wdata;
            GPIO_OCLR:    odata_d  = odata_q & ~wdata;
            GPIO_OSET:    odata_d  = odata_q | wdata;
            GPIO_OXOR:    odata_d  = odata_q ^ wdata;
            GPIO_IMASK:   imask_d  = wdata;
            GPIO_ITYPE:   itype_d  = wdata;
            GPIO_IPOL:    ipol_d   = wdata;
            GPIO_ILATCLR: ilat_clr = wdata;
            default:      ;
         endcase
      end
   end

   // Interrupt events; new events override a same-cycle clear
   always_comb begin
      edge_hit  = (sync ^ prev_q) & ~(sync ^ ipol_q);
      level_hit = ~(sync ^ ipol_q);
      irq_event = (itype_q & edge_hit) | (~itype_q & level_hit);
      ilat_d    = (ilat_q & ~ilat_clr) | irq_event;
   end

   // Read-back mux; write-only and reserved selects return zero
   always_comb begin
      rd_val = '0;
      case (sel)
         GPIO_DIR:   rd_val = dir_q;
         GPIO_IDATA: rd_val = sync;
         GPIO_ODATA: rd_val = odata_q;
         GPIO_IMASK: rd_val = imask_q;
         GPIO_ITYPE: rd_val = itype_q;
         GPIO_IPOL:  rd_val = ipol_q;
         GPIO_ILAT:  rd_val = ilat_q;
         default:    rd_val = '0;
      endcase
   end

   // State registers, read data and the registered interrupt line
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         prev_q  <= '0;
         dir_q   <= '0;
         odata_q <= '0;
         imask_q <= '0;
         itype_q <= '0;
         ipol_q  <= '0;
         ilat_q  <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         prev_q  <= sync;
         dir_q   <= dir_d;
         odata_q <= odata_d;
         imask_q <= imask_d;
         itype_q <= itype_d;
         ipol_q  <= ipol_d;
         ilat_q  <= ilat_d;
         irq_q   <= |(ilat_q & ~imask_q);
         if (read_en) begin
            rdata_q <= 32'(rd_val);
         end
      end
   end

   assign bus.reg_rdata = rdata_q;
   assign gpio_out      = odata_q;
   assign gpio_en       = dir_q;
   assign gpio_irq      = irq_q;
   assign gpio_ilat     = 32'(ilat_q);

endmodule

// File: tb/tb_gpio_core.sv
// Self-checking bench for gpio_core: directed table, interrupt sequences, randomized register ops.
module tb_gpio_core;

   localparam int unsigned N  = 24;
   localparam int unsigned AW = 32;
   localparam int unsigned PW = 2 * AW + 40;
   localparam logic [31:0] M  = 32'h00FF_FFFF;

   logic          clk;
   logic          nreset;
   logic [N-1:0]  gpio_in;
   logic [N-1:0]  gpio_out;
   logic [N-1:0]  gpio_en;
   logic          gpio_irq;
   logic [31:0]   gpio_ilat;

   int n_pass  = 0;
   int n_total = 0;

   gpio_core_if #(.PW(PW)) bus ();

   gpio_core #(
      .N  (N),
      .AW (AW),
      .PW (PW),
      .ID (0)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .bus       (bus.slave),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_en   (gpio_en),
      .gpio_irq  (gpio_irq),
      .gpio_ilat (gpio_ilat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   typedef struct {
      logic        wr;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [31:0] exp_out;
      logic [31:0] exp_en;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Build a packet with junk in the ignored fields
   function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [3:0] sel,
                                            input logic [31:0] data);
      logic [PW-1:0] p;
      p          = '0;
      p[0]       = wr;
      p[2:1]     = 2'($urandom);
      p[7:3]     = 5'($urandom);
      p[39:8]    = {25'd0, sel, 3'd0};
      p[71:40]   = data;
      p[103:72]  = $urandom;
      return p;
   endfunction

   task automatic bus_write(input logic [3:0] sel, input logic [31:0] data);
      @(negedge clk);
      bus.reg_access = 1'b1;
      bus.reg_packet = mk_pkt(1'b1, sel, data);
      @(posedge clk);
      #1;
      bus.reg_access = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] sel, output logic [31:0] rd);
      @(negedge clk);
      bus.reg_access = 1'b1;
      bus.reg_packet = mk_pkt(1'b0, sel, 32'd0);
      @(posedge clk);
      #1;
      bus.reg_access = 1'b0;
      rd = bus.reg_rdata;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model of the software-visible registers
   logic [31:0] m_dir, m_odata, m_imask, m_itype, m_ipol, m_last_rd;

   function automatic logic [31:0] model_read(input logic [3:0] sel, input logic [31:0] pins);
      case (sel)
         4'd0:    return m_dir;
         4'd1:    return pins & M;
         4'd2:    return m_odata;
         4'd6:    return m_imask;
         4'd7:    return m_itype;
         4'd8:    return m_ipol;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [3:0] sel, input logic [31:0] d);
      logic [31:0] v;
      v = d & M;
      case (sel)
         4'd0: m_dir   = v;
         4'd2: m_odata = v;
         4'd3: m_odata = m_odata & ~v;
         4'd4: m_odata = m_odata | v;
         4'd5: m_odata = m_odata ^ v;
         4'd6: m_imask = v;
         4'd7: m_itype = v;
         4'd8: m_ipol  = v;
         default: ;
      endcase
   endtask

   vec_t        tbl[$];
   logic [31:0] rd;

   initial begin
      nreset         = 1'b0;
      gpio_in        = '0;
      bus.reg_access = 1'b0;
      bus.reg_packet = '0;

      // Reset state
      cycles(3);
      check("reset gpio_out", 32'(gpio_out), 32'd0);
      check("reset gpio_en", 32'(gpio_en), 32'd0);
      check("reset gpio_irq", 32'(gpio_irq), 32'd0);
      check("reset reg_rdata", bus.reg_rdata, 32'd0);
      check("reset gpio_ilat", gpio_ilat, 32'd0);
      @(negedge clk);
      nreset = 1'b1;

      // Directed output/direction table
      tbl.push_back('{1'b1, 4'd2,  32'h0000_0001, 32'h000001, 32'h000000, 32'h0});
      tbl.push_back('{1'b1, 4'd4,  32'h0000_0008, 32'h000009, 32'h000000, 32'h0});
      tbl.push_back('{1'b1, 4'd3,  32'h0000_0001, 32'h000008, 32'h000000, 32'h0});
      tbl.push_back('{1'b1, 4'd5,  32'h0000_000F, 32'h000007, 32'h000000, 32'h0});
      tbl.push_back('{1'b0, 4'd2,  32'h0,         32'h000007, 32'h000000, 32'h0000_0007});
      tbl.push_back('{1'b1, 4'd0,  32'h00FF_00FF, 32'h000007, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b0, 4'd0,  32'h0,         32'h000007, 32'hFF00FF, 32'h00FF_00FF});
      tbl.push_back('{1'b1, 4'd12, 32'hFFFF_FFFF, 32'h000007, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b0, 4'd12, 32'h0,         32'h000007, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b0, 4'd4,  32'h0,         32'h000007, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b1, 4'd2,  32'hFFFF_FFFF, 32'hFFFFFF, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b0, 4'd2,  32'h0,         32'hFFFFFF, 32'hFF00FF, 32'h00FF_FFFF});
      tbl.push_back('{1'b1, 4'd3,  32'h00FF_FFFF, 32'h000000, 32'hFF00FF, 32'h0});
      tbl.push_back('{1'b0, 4'd6,  32'h0,         32'h000000, 32'hFF00FF, 32'h0});
      foreach (tbl[i]) begin
         if (tbl[i].wr) begin
            bus_write(tbl[i].sel, tbl[i].data);
            check($sformatf("tbl[%0d] gpio_out", i), 32'(gpio_out), tbl[i].exp_out);
            check($sformatf("tbl[%0d] gpio_en", i), 32'(gpio_en), tbl[i].exp_en);
         end else begin
            bus_read(tbl[i].sel, rd);
            check($sformatf("tbl[%0d] reg_rdata", i), rd, tbl[i].exp_rd);
         end
      end

      // Reset asserted in the middle of a write clears state with no clock
      bus_write(4'd2, 32'h00AB_CDEF);
      bus_read(4'd2, rd);
      check("pre-reset readback", rd, 32'h00AB_CDEF);
      @(negedge clk);
      bus.reg_access = 1'b1;
      bus.reg_packet = mk_pkt(1'b1, 4'd4, 32'h00FF_FFFF);
      nreset         = 1'b0;
      #1;
      check("async reset gpio_out", 32'(gpio_out), 32'd0);
      check("async reset gpio_en", 32'(gpio_en), 32'd0);
      check("async reset reg_rdata", bus.reg_rdata, 32'd0);
      cycles(1);
      check("packet ignored in reset", 32'(gpio_out), 32'd0);
      @(negedge clk);
      bus.reg_access = 1'b0;
      nreset         = 1'b1;

      // Input synchronizer path
      @(negedge clk);
      gpio_in = 24'h000001;
      cycles(3);
      bus_read(4'd1, rd);
      check("IDATA read", rd, 32'h1);
      bus_write(4'd1, 32'h00FF_FFFF);
      bus_read(4'd1, rd);
      check("IDATA write ignored", rd, 32'h1);

      // Edge interrupts, rising polarity, only pin 0 unmasked
      @(negedge clk);
      gpio_in = '0;
      cycles(3);
      bus_write(4'd7, 32'h00FF_FFFF);
      bus_write(4'd8, 32'h00FF_FFFF);
      bus_write(4'd6, 32'h00FF_FFFE);
      bus_write(4'd10, 32'h00FF_FFFF);
      check("edge ilat cleared", gpio_ilat, 32'd0);
      cycles(1);
      check("edge irq idle", 32'(gpio_irq), 32'd0);
      @(negedge clk);
      gpio_in = 24'h000001;
      cycles(3);
      check("edge pin0 ilat", gpio_ilat, 32'h1);
      check("edge irq lags ilat", 32'(gpio_irq), 32'd0);
      cycles(1);
      check("edge pin0 irq", 32'(gpio_irq), 32'd1);
      @(negedge clk);
      gpio_in = 24'h000003;
      cycles(3);
      check("edge pin1 ilat", gpio_ilat, 32'h3);
      check("edge pin1 irq", 32'(gpio_irq), 32'd1);
      bus_write(4'd10, 32'h0000_0001);
      check("ilatclr pin0", gpio_ilat, 32'h2);
      cycles(1);
      check("masked pin1 no irq", 32'(gpio_irq), 32'd0);
      bus_read(4'd9, rd);
      check("ILAT read", rd, 32'h2);

      // Level interrupts, active low, unmasked
      @(negedge clk);
      gpio_in = '0;
      bus_write(4'd7, 32'h0);
      bus_write(4'd8, 32'h0);
      bus_write(4'd6, 32'h0);
      cycles(4);
      check("level ilat", gpio_ilat, M);
      check("level irq", 32'(gpio_irq), 32'd1);
      bus_write(4'd10, 32'h00FF_FFFF);
      check("level set wins over clear", gpio_ilat, M);
      bus_write(4'd8, 32'h00FF_FFFF);
      bus_write(4'd10, 32'h00FF_FFFF);
      check("level clear after polarity flip", gpio_ilat, 32'd0);
      cycles(2);
      check("level irq drops", 32'(gpio_irq), 32'd0);

      // Randomized register traffic against the model
      @(negedge clk);
      gpio_in = N'($urandom);
      m_dir   = $urandom & M;
      m_odata = $urandom & M;
      m_imask = $urandom & M;
      m_itype = $urandom & M;
      m_ipol  = $urandom & M;
      bus_write(4'd0, m_dir);
      bus_write(4'd2, m_odata);
      bus_write(4'd6, m_imask);
      bus_write(4'd7, m_itype);
      bus_write(4'd8, m_ipol);
      cycles(3);
      bus_read(4'd0, rd);
      check("rand init DIR", rd, m_dir);
      m_last_rd = m_dir;
      for (int i = 0; i < 150; i++) begin
         logic [3:0]  sel;
         logic        wr;
         logic [31:0] d;
         logic [31:0] exp;
         sel = 4'($urandom_range(0, 15));
         if (sel == 4'd9) sel = 4'd1;
         wr = 1'($urandom);
         d  = $urandom;
         if (wr) begin
            bus_write(sel, d);
            model_write(sel, d);
            check($sformatf("rand[%0d] gpio_out", i), 32'(gpio_out), m_odata);
            check($sformatf("rand[%0d] gpio_en", i), 32'(gpio_en), m_dir);
            check($sformatf("rand[%0d] rdata hold", i), bus.reg_rdata, m_last_rd);
         end else begin
            exp = model_read(sel, 32'(gpio_in));
            bus_read(sel, rd);
            check($sformatf("rand[%0d] read sel %0d", i, sel), rd, exp);
            m_last_rd = exp;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gpio_core.md
Name: gpio_core

Overview:
- Memory-mapped general-purpose I/O block with N pins, per-pin direction, output data and atomic set/clear/toggle writes.
- Input pins are synchronized; per-pin edge- or level-sensitive interrupts are latched, masked and combined into one interrupt line.
- Sits on the on-chip emesh register bus: it takes 104-bit register packets and returns 32-bit read data.

Parameters:
- N, 24, number of GPIO pins (1..32).
- AW, 32, packet address width.
- PW, 2*AW+40 (104), register packet width.
- ID, 0, block id, bits [10:8] of the destination address. Reserved and not decoded.

Ports:
- clk  in  1  single clock for all logic.
- nreset  in  1  asynchronous active-low reset.
- reg_access  in  1  register packet valid, sampled each cycle.
- reg_packet  in  PW  emesh packet. Fields: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
- gpio_in  in  N  asynchronous pin inputs.
- reg_rdata  out  32  registered read data.
- gpio_out  out  N  output data register.
- gpio_en  out  N  output enable per pin (1 = drive), equals the DIR register.
- gpio_irq  out  1  interrupt, OR of unmasked latched interrupts.
- gpio_ilat  out  32  interrupt latch, zero-extended from N bits.

Behaviour:
- Decode:
  - write_en = reg_access & write.
  - read_en = reg_access & ~write.
  - Register select = dstaddr[6:3].
  - Only data[N-1:0] is used. datamode, ctrlmode and srcaddr are ignored.
- Register map (select value: name, access):
  - 0: DIR, rw.
  - 1: IDATA, ro (synchronized inputs). Writes are ignored.
  - 2: ODATA, rw.
  - 3: OCLR, wo (odata &= ~data).
  - 4: OSET, wo (odata |= data).
  - 5: OXOR, wo (odata ^= data).
  - 6: IMASK, rw (1 = masked).
  - 7: ITYPE, rw (1 = edge, 0 = level).
  - 8: IPOL, rw (1 = rising/high, 0 = falling/low).
  - 9: ILAT, ro.
  - 10: ILATCLR, wo (clears bits set in data).
  - 11-15: reserved. Reads return 0; writes are ignored.
- Writes take effect on the clock edge where write_en is sampled. gpio_out/gpio_en change one cycle after the packet is presented.
- Reads:
  - reg_rdata is registered, with a latency of 1 cycle after read_en.
  - The value is zero-extended to 32 bits.
  - reg_rdata holds its last value when there is no read.
  - Write-only registers read as 0.
- Input path: gpio_in passes through a 2-flop synchronizer (reset to 0), giving 2 cycles from pin to IDATA. A registered copy of the synchronized value is used for edge detect.
- Interrupt detection, per pin i:
  - Edge mode: fires when sync[i] differs from prev[i] and sync[i] == IPOL[i].
  - Level mode: fires while sync[i] == IPOL[i].
- ILAT:
  - Each bit sets when an event fires and stays set until cleared by ILATCLR.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Masking does not block latching; it only gates the interrupt.
- gpio_irq = |(ILAT & ~IMASK), registered, so the interrupt follows ILAT by one cycle.
- Reset (asynchronous, active-low): all registers, synchronizer and edge flops, ILAT, gpio_out, gpio_en, gpio_irq and reg_rdata go to 0. The reset value of IPOL is 0, so a level interrupt is pending immediately after reset for pins held low. Software must program IMASK/IPOL before use; IMASK also resets to 0.
- If reset is asserted mid-operation, state clears immediately with no clock needed. Packets presented while nreset = 0 are ignored.
- Consecutive writes on back-to-back cycles each take effect in their own cycle.

Decomposition:
- Shared package: register select constants (GPIO_DIR … GPIO_ILATCLR) and the packet field offsets.
- One natural sub-module: gpio_sync, an N-bit 2-flop input synchronizer with async reset.
- Packet field extraction stays inline.

Test Plan:
- Reset: hold nreset = 0 → gpio_out = 0, gpio_en = 0, gpio_irq = 0, reg_rdata = 0. Check reset asserted mid-write clears immediately.
- Output set/clear/toggle:
  - Write ODATA = 0x000001 → gpio_out = 0x000001 next cycle.
  - OSET 0x000008 → 0x000009.
  - OCLR 0x000001 → 0x000008.
  - OXOR 0x00000F → 0x000007.
  - Read ODATA → reg_rdata = 0x00000007.
- Direction: write DIR 0xFF00FF → gpio_en = 0xFF00FF. Read DIR returns 0x00FF00FF.
- Input read: drive gpio_in = 0x000001 and wait 3 cycles. Read IDATA → reg_rdata = 0x00000001 one cycle later. A write to IDATA leaves it unchanged.
- Edge interrupt:
  - Set ITYPE = 0xFFFFFF, IPOL = 0xFFFFFF, IMASK = 0xFFFFFE, then raise gpio_in[0].
  - Expect gpio_ilat[0] = 1, then gpio_irq = 1.
  - Raising pin 1 latches ilat[1] but leaves irq driven only by pin 0.
  - ILATCLR 0x000001 → gpio_irq = 0.
- Level interrupt: ITYPE = 0, IPOL = 0, unmasked, pin low → ilat set. A clear while the pin is still low re-sets it (set wins).
